vpu_req_queue: RTL
==================

# vpu_req_queue

Instruction queue and in-flight tracker placed directly upstream of the VPU request interface. Buffers host instructions (with stream IDs) in a FIFO and issues them to the VPU decoder over a valid/ready handshake. Limits the number of outstanding instructions and matches each VPU response against the oldest issued stream ID. Reports one completion pulse per response and a sticky error on ordering violations.

## Interface
- `INSTR_WIDTH`, default 64: encoded VPU instruction width.
- `STREAM_ID_WIDTH`, default 8: stream ID width.
- `DEPTH`, default 8: instruction FIFO entries; power of 2, ≥2.
- `MAX_INFLIGHT`, default 4: maximum issued-but-unanswered instructions; power of 2, ≥1.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `host_valid_i` in 1: host instruction valid.
- `host_ready_o` out 1: queue can accept an instruction.
- `host_instr_i` in INSTR_WIDTH: instruction word.
- `host_stream_id_i` in STREAM_ID_WIDTH: stream ID tagged to the instruction.
- `req_valid_o` out 1: instruction offered to the VPU.
- `req_ready_i` in 1: VPU accepts the instruction.
- `req_instr_o` out INSTR_WIDTH: FIFO head instruction.
- `req_stream_id_o` out STREAM_ID_WIDTH: FIFO head stream ID.
- `rsp_valid_i` in 1: VPU response pulse, one cycle per completed instruction.
- `rsp_stream_id_i` in STREAM_ID_WIDTH: stream ID of the completed instruction.
- `cpl_valid_o` out 1: completion pulse to the host.
- `cpl_stream_id_o` out STREAM_ID_WIDTH: completed stream ID.
- `err_o` out 1: sticky protocol error.
- `err_clr_i` in 1: clears `err_o`.
- `count_o` out log2(DEPTH)+1: FIFO occupancy.
- `inflight_o` out log2(MAX_INFLIGHT)+1: outstanding instruction count.
- `idle_o` out 1: FIFO empty and no instructions outstanding.

## Operation
- **Instruction FIFO**
  - Stores {instr, stream_id}; depth DEPTH; wrap-around read/write pointers plus an occupancy counter.
  - Push when `host_valid_i && host_ready_o`.
  - `host_ready_o = (count_o < DEPTH)`, derived from registered state only. It has no combinational dependence on `req_ready_i`, so a full FIFO refuses a push even when a pop occurs in the same cycle.
- **Issue**
  - `req_valid_o = (count_o != 0) && (inflight_o < MAX_INFLIGHT)`.
  - Issue when `req_valid_o && req_ready_i`: the entry pops and its stream ID is pushed into the in-flight tag FIFO (depth MAX_INFLIGHT).
  - `req_instr_o` and `req_stream_id_o` show the FIFO head whenever `count_o != 0`; they hold stable while `req_valid_o && !req_ready_i`.
- **Response matching**, on `rsp_valid_i`:
  - `inflight_o == 0`: set `err_o`; counters are unchanged; no completion is produced.
  - Otherwise the tag FIFO head is popped. `cpl_valid_o` is set for the next cycle with `cpl_stream_id_o = rsp_stream_id_i`. If `rsp_stream_id_i` differs from the head tag, `err_o` is set; the completion is still reported.
- **Simultaneous events**
  - Issue and response in the same cycle: `inflight_o` is unchanged; tag FIFO push and pop both occur.
  - Push and pop in the same cycle (not full): `count_o` is unchanged.
  - `err_clr_i` together with a new error: the set wins.
- `idle_o = (count_o == 0) && (inflight_o == 0)`.

## Timing
- **Reset values** (`rst_n` low at a clock edge, including mid-operation):
  - Pointers, counters, tag FIFO, `err_o`, `cpl_valid_o`, `cpl_stream_id_o`: all 0.
  - Outputs after reset: `req_valid_o=0`, `host_ready_o=1`, `idle_o=1`, `count_o=0`, `inflight_o=0`. `req_instr_o` and `req_stream_id_o` are don't-care while `req_valid_o=0`.
  - Instructions pending or in flight at reset are discarded; no completions are produced for them.
- **Latencies**
  - Push at edge N → `req_valid_o` high in cycle N+1 at the earliest. There is no bypass from host to VPU.
  - Response at edge N → `cpl_valid_o` high for exactly cycle N+1. No backpressure on completions.
  - `inflight_o` and `count_o` update at the accepting edge. `host_ready_o` and `req_valid_o` reflect the new values in the following cycle.
- **Throughput**: one push and one issue per cycle sustained when not full and not at MAX_INFLIGHT.

## Test plan
- **Basic flow**, `req_ready_i=1`: push IDs 1, 2, 3 on consecutive cycles → issued on cycles +1, +2, +3. Responses with IDs 1, 2, 3 → `cpl_valid_o` pulses with IDs 1, 2, 3. `idle_o` returns to 1 and `err_o` stays 0.
- **Full FIFO**, `req_ready_i=0`: push 9 instructions with DEPTH=8 → `host_ready_o` drops after the 8th push and `count_o=8`. The 9th is accepted only after one pop. FIFO order is preserved across pointer wrap.
- **In-flight limit**, MAX_INFLIGHT=4, `req_ready_i=1`, no responses: 6 queued → exactly 4 issued, `req_valid_o=0`, `inflight_o=4`. One response → the 5th issues the next cycle.
- **Ordering error**: issue IDs 5 then 6; respond with 6 first → `err_o=1` and `cpl_stream_id_o=6`. `inflight_o=1`. `err_clr_i` → `err_o=0`.
- **Spurious response**: `rsp_valid_i` with `inflight_o=0` → `err_o=1`, no `cpl_valid_o`, counters unchanged.
- **Reset mid-operation**: reset with 3 queued and 2 in flight → next cycle `count_o=0`, `inflight_o=0`, `idle_o=1`, `req_valid_o=0`, and no completions afterwards.

Source files
------------

// File: rtl/vpu_req_queue.sv
// Instruction FIFO and in-flight tag tracker in front of the VPU request port.
// Issues queued instructions under an outstanding limit and checks response order.
module vpu_req_queue #(
    parameter int INSTR_WIDTH     = 64,
    parameter int STREAM_ID_WIDTH = 8,
    parameter int DEPTH           = 8,
    parameter int MAX_INFLIGHT    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           host_valid_i,
    output logic                           host_ready_o,
    input  logic [INSTR_WIDTH-1:0]         host_instr_i,
    input  logic [STREAM_ID_WIDTH-1:0]     host_stream_id_i,
    output logic                           req_valid_o,
    input  logic                           req_ready_i,
    output logic [INSTR_WIDTH-1:0]         req_instr_o,
    output logic [STREAM_ID_WIDTH-1:0]     req_stream_id_o,
    input  logic                           rsp_valid_i,
    input  logic [STREAM_ID_WIDTH-1:0]     rsp_stream_id_i,
    output logic                           cpl_valid_o,
    output logic [STREAM_ID_WIDTH-1:0]     cpl_stream_id_o,
    output logic                           err_o,
    input  logic                           err_clr_i,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic [$clog2(MAX_INFLIGHT):0]  inflight_o,
    output logic                           idle_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int FW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [FW-1:0] MAX_C     = FW'(MAX_INFLIGHT);
    localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_INFLIGHT - 1);

    logic [INSTR_WIDTH-1:0]     r_instr_mem [DEPTH];
    logic [STREAM_ID_WIDTH-1:0] r_sid_mem   [DEPTH];
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;

    logic [STREAM_ID_WIDTH-1:0] w_tag_q [MAX_INFLIGHT];
    logic [TW-1:0]              r_tag_wr;
    logic [TW-1:0]              r_tag_rd;
    logic [FW-1:0]              r_inflight;

    logic                       r_err;
    logic                       r_cpl_valid;
    logic [STREAM_ID_WIDTH-1:0] r_cpl_sid;

    logic                       w_push;
    logic                       w_issue;
    logic                       w_rsp_ok;
    logic                       w_set_err;
    logic [STREAM_ID_WIDTH-1:0] w_tag_head;

    // Ready/valid come only from registered occupancy, so a full FIFO never
    // accepts a push in the same cycle as a pop.
    assign host_ready_o    = (r_count < DEPTH_C);
    assign req_valid_o     = (r_count != '0) && (r_inflight < MAX_C);
    assign req_instr_o     = r_instr_mem[r_rd_ptr];
    assign req_stream_id_o = r_sid_mem[r_rd_ptr];
    assign w_push          = host_valid_i && host_ready_o;
    assign w_issue         = req_valid_o && req_ready_i;
    assign w_tag_head      = w_tag_q[r_tag_rd];
    assign w_rsp_ok        = rsp_valid_i && (r_inflight != '0);
    assign w_set_err       = (rsp_valid_i && (r_inflight == '0)) ||
                             (w_rsp_ok && (rsp_stream_id_i != w_tag_head));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= host_instr_i;
            r_sid_mem[r_wr_ptr]   <= host_stream_id_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_INFLIGHT; gi++) begin : g_tag
            logic [STREAM_ID_WIDTH-1:0] r_tag;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_tag <= '0;
                end else if (w_issue && (r_tag_wr == TW'(gi))) begin
                    r_tag <= r_sid_mem[r_rd_ptr];
                end
            end
            assign w_tag_q[gi] = r_tag;
        end
    endgenerate

    // Tag pointers wrap explicitly so a single-entry tracker stays at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_inflight <= '0;
        end else begin
            if (w_issue) r_tag_wr <= (r_tag_wr == TAG_LAST) ? '0 : r_tag_wr + TW'(1);
            if (w_rsp_ok) r_tag_rd <= (r_tag_rd == TAG_LAST) ? '0 : r_tag_rd + TW'(1);
            case ({w_issue, w_rsp_ok})
                2'b10:   r_inflight <= r_inflight + FW'(1);
                2'b01:   r_inflight <= r_inflight - FW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err       <= 1'b0;
            r_cpl_valid <= 1'b0;
            r_cpl_sid   <= '0;
        end else begin
            if (w_set_err) r_err <= 1'b1;
            else if (err_clr_i) r_err <= 1'b0;
            r_cpl_valid <= w_rsp_ok;
            if (w_rsp_ok) r_cpl_sid <= rsp_stream_id_i;
        end
    end

    assign cpl_valid_o     = r_cpl_valid;
    assign cpl_stream_id_o = r_cpl_sid;
    assign err_o           = r_err;
    assign count_o         = r_count;
    assign inflight_o      = r_inflight;
    assign idle_o          = (r_count == '0) && (r_inflight == '0);
endmodule
